// File: rtl/fft_pkg.sv
// Shared FFT definitions: default widths, complex types and fixed-point helpers.
package fft_pkg;

   localparam int unsigned FFT_DATA_WIDTH = 16;
   localparam int unsigned FFT_FRAC_BITS  = 15;
   // Two integer bits so that +1.0 is exactly representable in a twiddle.
   localparam int unsigned FFT_TWID_WIDTH = FFT_FRAC_BITS + 2;

   // Real part at index 0, imaginary part at index 1.
   typedef logic signed [1:0][FFT_DATA_WIDTH-1:0] cplx_t;
   typedef logic signed [1:0][FFT_TWID_WIDTH-1:0] twid_t;

   // Clamp a signed value into the range of a signed 'width'-bit number.
   function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                              input int unsigned       width);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (width - 1));
      if (value > max_v) begin
         return max_v;
      end else if (value < min_v) begin
         return min_v;
      end
      return value;
   endfunction

   // Round half up, then drop 'frac' fractional bits.
   function automatic logic signed [63:0] round_shift(input logic signed [63:0] value,
                                                      input int unsigned       frac);
      return (value + (64'sd1 <<< (frac - 1))) >>> frac;
   endfunction

endpackage

// File: rtl/cmul.sv
// Combinational complex multiply b*W with round-half-up and saturation to DATA_WIDTH.
module cmul
   import fft_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = FFT_DATA_WIDTH,
   parameter  int unsigned FRAC_BITS  = FFT_FRAC_BITS,
   localparam int unsigned TWID_WIDTH = FRAC_BITS + 2
) (
   input  logic signed [1:0][DATA_WIDTH-1:0] b_i,
   input  logic signed [1:0][TWID_WIDTH-1:0] w_i,
   output logic signed [DATA_WIDTH-1:0]      re_o,
   output logic signed [DATA_WIDTH-1:0]      im_o
);

   // One extra bit above the raw product so the sum/difference of two products cannot wrap.
   localparam int unsigned PROD_WIDTH = DATA_WIDTH + TWID_WIDTH + 1;

   logic signed [PROD_WIDTH-1:0] w_br;
   logic signed [PROD_WIDTH-1:0] w_bi;
   logic signed [PROD_WIDTH-1:0] w_wr;
   logic signed [PROD_WIDTH-1:0] w_wi;
   logic signed [PROD_WIDTH-1:0] w_prod_re;
   logic signed [PROD_WIDTH-1:0] w_prod_im;

   // Full-precision products, then round and saturate back to data width.
   always_comb begin
      w_br      = PROD_WIDTH'($signed(b_i[0]));
      w_bi      = PROD_WIDTH'($signed(b_i[1]));
      w_wr      = PROD_WIDTH'($signed(w_i[0]));
      w_wi      = PROD_WIDTH'($signed(w_i[1]));
      w_prod_re = (w_br * w_wr) - (w_bi * w_wi);
      w_prod_im = (w_br * w_wi) + (w_bi * w_wr);
      re_o      = DATA_WIDTH'(sat(round_shift(64'(w_prod_re), FRAC_BITS), DATA_WIDTH));
      im_o      = DATA_WIDTH'(sat(round_shift(64'(w_prod_im), FRAC_BITS), DATA_WIDTH));
   end

endmodule

// File: rtl/radix2_butterfly.sv
// Two-stage pipelined radix-2 DIT butterfly: a_o = a + W*b, b_o = a - W*b, saturating.
module radix2_butterfly
   import fft_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = FFT_DATA_WIDTH,
   parameter  int unsigned FRAC_BITS  = FFT_FRAC_BITS,
   localparam int unsigned TWID_WIDTH = FRAC_BITS + 2
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              valid_i,
   input  logic signed [1:0][TWID_WIDTH-1:0] twid_i,
   input  logic signed [1:0][DATA_WIDTH-1:0] a_i,
   input  logic signed [1:0][DATA_WIDTH-1:0] b_i,
   output logic                              valid_o,
   output logic signed [1:0][DATA_WIDTH-1:0] a_o,
   output logic signed [1:0][DATA_WIDTH-1:0] b_o
);

   // Rotated b, combinational from the current inputs.
   logic signed [DATA_WIDTH-1:0] b_rot_re;
   logic signed [DATA_WIDTH-1:0] b_rot_im;

   logic signed [1:0][DATA_WIDTH-1:0] r_a;
   logic signed [1:0][DATA_WIDTH-1:0] r_rot;
   logic                              r_valid1;
   logic signed [1:0][DATA_WIDTH-1:0] r_a_o;
   logic signed [1:0][DATA_WIDTH-1:0] r_b_o;
   logic                              r_valid2;

   logic signed [1:0][DATA_WIDTH:0]   w_sum;
   logic signed [1:0][DATA_WIDTH:0]   w_dif;
   logic signed [1:0][DATA_WIDTH-1:0] w_sum_sat;
   logic signed [1:0][DATA_WIDTH-1:0] w_dif_sat;

   cmul #(
      .DATA_WIDTH(DATA_WIDTH),
      .FRAC_BITS (FRAC_BITS)
   ) u_cmul (
      .b_i (b_i),
      .w_i (twid_i),
      .re_o(b_rot_re),
      .im_o(b_rot_im)
   );

   // Stage 1: capture a and the rotated b; data loads regardless of valid_i.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_a      <= '0;
         r_rot    <= '0;
         r_valid1 <= 1'b0;
      end else begin
         r_a      <= a_i;
         r_rot    <= {b_rot_im, b_rot_re};
         r_valid1 <= valid_i;
      end
   end

   // Per-component sum and difference at one extra bit, then saturate.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         w_sum[i]     = (DATA_WIDTH + 1)'($signed(r_a[i])) + (DATA_WIDTH + 1)'($signed(r_rot[i]));
         w_dif[i]     = (DATA_WIDTH + 1)'($signed(r_a[i])) - (DATA_WIDTH + 1)'($signed(r_rot[i]));
         w_sum_sat[i] = DATA_WIDTH'(sat(64'($signed(w_sum[i])), DATA_WIDTH));
         w_dif_sat[i] = DATA_WIDTH'(sat(64'($signed(w_dif[i])), DATA_WIDTH));
      end
   end

   // Stage 2: register the saturated results and the output valid.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_a_o    <= '0;
         r_b_o    <= '0;
         r_valid2 <= 1'b0;
      end else begin
         r_a_o    <= w_sum_sat;
         r_b_o    <= w_dif_sat;
         r_valid2 <= r_valid1;
      end
   end

   assign a_o     = r_a_o;
   assign b_o     = r_b_o;
   assign valid_o = r_valid2;

endmodule

// File: tb/tb_radix2_butterfly.sv
// Directed self-checking bench for radix2_butterfly (Q15 raw integer vectors).
module tb_radix2_butterfly;

   logic                     clk;
   logic                     rst_n;
   logic                     valid_in;
   logic signed [1:0][16:0]  twid;
   logic signed [1:0][15:0]  a_in;
   logic signed [1:0][15:0]  b_in;
   logic                     valid_out;
   logic signed [1:0][15:0]  a_out;
   logic signed [1:0][15:0]  b_out;

   int n_checks;
   int n_fail;

   radix2_butterfly #(
      .DATA_WIDTH(16),
      .FRAC_BITS (15)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .valid_i(valid_in),
      .twid_i (twid),
      .a_i    (a_in),
      .b_i    (b_in),
      .valid_o(valid_out),
      .a_o    (a_out),
      .b_o    (b_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
      end
   endtask

   task automatic set_in(input int wr, input int wi, input int ar, input int ai,
                         input int br, input int bi);
      twid[0] = 17'(wr);
      twid[1] = 17'(wi);
      a_in[0] = 16'(ar);
      a_in[1] = 16'(ai);
      b_in[0] = 16'(br);
      b_in[1] = 16'(bi);
   endtask

   // Apply one butterfly at a negedge, check b_rot now and the outputs two edges later.
   task automatic vec(input string tag, input int wr, input int wi, input int ar, input int ai,
                      input int br, input int bi, input int rr, input int ri,
                      input int aor, input int aoi, input int bor, input int boi);
      set_in(wr, wi, ar, ai, br, bi);
      valid_in = 1'b1;
      #1;
      chk({tag, ".rot_re"}, dut.b_rot_re, rr);
      chk({tag, ".rot_im"}, dut.b_rot_im, ri);
      @(negedge clk);
      valid_in = 1'b0;
      @(negedge clk);
      chk({tag, ".valid"}, {31'd0, valid_out}, 1);
      chk({tag, ".a_re"}, $signed(a_out[0]), aor);
      chk({tag, ".a_im"}, $signed(a_out[1]), aoi);
      chk({tag, ".b_re"}, $signed(b_out[0]), bor);
      chk({tag, ".b_im"}, $signed(b_out[1]), boi);
   endtask

   int pv [8] = '{1, 1, 1, 1, 0, 1, 0, 0};

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      valid_in = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk("reset.valid", {31'd0, valid_out}, 0);
      chk("reset.a_re", $signed(a_out[0]), 0);
      chk("reset.b_re", $signed(b_out[0]), 0);
      rst_n = 1'b1;
      @(negedge clk);

      vec("unity", 32768, 0, 16384, 0, 8192, 0, 8192, 0, 24576, 0, 8192, 0);
      vec("w_m45", 23170, -23170, 16384, 0, 16384, 0, 11585, -11585,
          27969, -11585, 4799, 11585);
      vec("w_mj", 0, -32768, 16384, 8192, 8192, -8192, -8192, -8192,
          8192, 0, 24576, 16384);
      vec("sat_pos", 32768, 0, 32767, 0, 32767, 0, 32767, 0, 32767, 0, 0, 0);
      vec("sat_neg", 32768, 0, -32768, 0, -32768, 0, -32768, 0, -32768, 0, 0, 0);
      vec("rnd_half", 1, 0, 0, 0, 16384, 0, 1, 0, 1, 0, -1, 0);
      vec("rnd_below", 1, 0, 0, 0, 16383, 0, 0, 0, 0, 0, 0, 0);
      vec("rnd_neg_half", 1, 0, 0, 0, -16384, 0, 0, 0, 0, 0, 0, 0);
      vec("big_twid", 65535, 0, 0, 0, 32767, 0, 32767, 0, 32767, 0, -32767, 0);

      // Back-to-back valids with a gap; W = 1.0 so a_o = a + b and b_o = a - b.
      for (int t = 0; t < 10; t++) begin
         if (t >= 2) begin
            chk($sformatf("pipe%0d.valid", t - 2), {31'd0, valid_out}, pv[t - 2]);
            if (pv[t - 2] == 1) begin
               chk($sformatf("pipe%0d.a_re", t - 2), $signed(a_out[0]), 1100 * (t - 1));
               chk($sformatf("pipe%0d.b_re", t - 2), $signed(b_out[0]), 900 * (t - 1));
            end
         end
         if (t < 8) begin
            set_in(32768, 0, 1000 * (t + 1), 0, 100 * (t + 1), 0);
            valid_in = pv[t][0];
         end else begin
            valid_in = 1'b0;
         end
         @(negedge clk);
      end

      // Reset mid-stream discards in-flight work.
      set_in(32768, 0, 5000, 0, 1000, 0);
      valid_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst.valid", {31'd0, valid_out}, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst.valid", {31'd0, valid_out}, 0);
      chk("rst.a_re", $signed(a_out[0]), 0);
      chk("rst.b_re", $signed(b_out[0]), 0);
      chk("rst.a_im", $signed(a_out[1]), 0);
      rst_n    = 1'b1;
      valid_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("post_rst%0d.valid", k), {31'd0, valid_out}, 0);
      end
      set_in(32768, 0, 7, 0, 3, 0);
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      chk("first.valid_early", {31'd0, valid_out}, 0);
      @(negedge clk);
      chk("first.valid", {31'd0, valid_out}, 1);
      chk("first.a_re", $signed(a_out[0]), 10);
      chk("first.b_re", $signed(b_out[0]), 4);
      @(negedge clk);
      chk("first.valid_drop", {31'd0, valid_out}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
